// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared types and constants for the HDMI data-island path:
//               island phase encoding, packet source indices, phase lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  // Island phase, as seen on the scheduler's phase output
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PREAMBLE    = 3'd1,
    LEAD_GUARD  = 3'd2,
    PACKET      = 3'd3,
    TRAIL_GUARD = 3'd4
  } island_phase_t;

  // Packet source indices; lower index wins arbitration
  localparam logic [1:0] SRC_AUD = 2'd0;
  localparam logic [1:0] SRC_ACR = 2'd1;
  localparam logic [1:0] SRC_AVI = 2'd2;
  localparam logic [1:0] SRC_AIF = 2'd3;

  // Phase lengths in pixel clocks
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PKT_LEN      = 32;

  // Encode a one-hot source vector into its index (zero vector maps to SRC_AUD)
  function automatic logic [1:0] onehot_to_src(input logic [3:0] oh);
    logic [1:0] idx;
    idx = SRC_AUD;
    if (oh[1]) idx = SRC_ACR;
    if (oh[2]) idx = SRC_AVI;
    if (oh[3]) idx = SRC_AIF;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/island_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : island_arbiter
// Description : Holds the latched packet requests and picks the highest
//               priority pending source (bit 0 highest) as a one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module island_arbiter
  import hdmi_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_in,
  input  logic [3:0] req,
  input  logic [3:0] grant,
  output logic [3:0] pending,
  output logic [3:0] sel_onehot,
  output logic [1:0] sel_idx
);

  logic [3:0] r_pending;

  // Clear served bits, then OR in new pulses so a request landing on its
  // own grant cycle is not lost
  always_ff @(posedge clk_pix or posedge rst_in) begin
    if (rst_in) begin
      r_pending <= 4'd0;
    end else begin
      r_pending <= (r_pending & ~grant) | req;
    end
  end

  assign pending    = r_pending;
  // Isolate the lowest set bit: fixed priority with bit 0 on top
  assign sel_onehot = r_pending & (~r_pending + 4'd1);
  assign sel_idx    = onehot_to_src(sel_onehot);

endmodule
`default_nettype wire

// File: rtl/island_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : island_scheduler
// Description : Sequences one HDMI data island per line in horizontal
//               blanking: preamble, leading guard, up to MAX_PKTS packets,
//               trailing guard. Aborts cleanly if the visible area starts.
// Revision    : 1.0 - initial release
// ============================================================================
module island_scheduler
  import hdmi_pkg::*;
#(
  parameter int ISLAND_START = 650,
  parameter int MAX_PKTS     = 2,
  parameter int H_TOTAL      = 800
) (
  input  logic       clk_pix,
  input  logic       rst_in,
  input  logic [9:0] sx,
  input  logic       de,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [2:0] phase,
  output logic [1:0] pkt_sel,
  output logic [4:0] pkt_idx,
  output logic [3:0] pending,
  output logic       abort
);

  // Refuse configurations whose island would not fit in the blanking window
  if (ISLAND_START + 12 + 32 * MAX_PKTS > H_TOTAL - 12) begin : g_bad_island_fit
    $error("island_scheduler: island does not fit before end of line");
  end
  if (MAX_PKTS < 1 || MAX_PKTS > 3) begin : g_bad_max_pkts
    $error("island_scheduler: MAX_PKTS must be 1..3");
  end

  localparam logic [1:0] c_max_pkts  = 2'(MAX_PKTS);
  localparam logic [2:0] c_pre_last  = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0] c_grd_last  = 3'(GUARD_LEN - 1);
  localparam logic [4:0] c_pkt_last  = 5'(PKT_LEN - 1);
  localparam logic [9:0] c_start_sx  = 10'(ISLAND_START);

  island_phase_t r_phase, w_phase;
  logic [2:0]    r_cnt, w_cnt;
  logic [1:0]    r_pkt_cnt, w_pkt_cnt;
  logic [4:0]    r_pkt_idx, w_pkt_idx;
  logic [1:0]    r_pkt_sel, w_pkt_sel;
  logic [3:0]    r_grant, w_grant;
  logic          r_abort, w_abort;
  logic          w_start_pkt;
  logic [3:0]    w_sel_onehot;
  logic [1:0]    w_sel_idx;

  island_arbiter u_arbiter (
    .clk_pix    (clk_pix),
    .rst_in     (rst_in),
    .req        (req),
    .grant      (r_grant),
    .pending    (pending),
    .sel_onehot (w_sel_onehot),
    .sel_idx    (w_sel_idx)
  );

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk_pix or posedge rst_in) begin
    if (rst_in) begin
      r_phase   <= IDLE;
      r_cnt     <= 3'd0;
      r_pkt_cnt <= 2'd0;
      r_pkt_idx <= 5'd0;
      r_pkt_sel <= 2'd0;
      r_grant   <= 4'd0;
      r_abort   <= 1'b0;
    end else begin
      r_phase   <= w_phase;
      r_cnt     <= w_cnt;
      r_pkt_cnt <= w_pkt_cnt;
      r_pkt_idx <= w_pkt_idx;
      r_pkt_sel <= w_pkt_sel;
      r_grant   <= w_grant;
      r_abort   <= w_abort;
    end
  end

  // Next-state and next-output logic; de during an island overrides all
  always_comb begin
    w_phase     = r_phase;
    w_cnt       = r_cnt;
    w_pkt_cnt   = r_pkt_cnt;
    w_pkt_idx   = 5'd0;
    w_pkt_sel   = 2'd0;
    w_grant     = 4'd0;
    w_abort     = 1'b0;
    w_start_pkt = 1'b0;

    case (r_phase)
      IDLE: begin
        w_cnt     = 3'd0;
        w_pkt_cnt = 2'd0;
        if (sx == c_start_sx && pending != 4'd0) begin
          w_phase = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (r_cnt == c_pre_last) begin
          w_phase = LEAD_GUARD;
          w_cnt   = 3'd0;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      LEAD_GUARD: begin
        if (r_cnt == c_grd_last) begin
          w_start_pkt = 1'b1;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      PACKET: begin
        if (r_pkt_idx == c_pkt_last) begin
          // The current grant cleared long ago, so pending is already net of it
          if (pending != 4'd0 && r_pkt_cnt < c_max_pkts) begin
            w_start_pkt = 1'b1;
          end else begin
            w_phase = TRAIL_GUARD;
            w_cnt   = 3'd0;
          end
        end else begin
          w_pkt_idx = r_pkt_idx + 5'd1;
          w_pkt_sel = r_pkt_sel;
        end
      end
      TRAIL_GUARD: begin
        if (r_cnt == c_grd_last) begin
          w_phase = IDLE;
          w_cnt   = 3'd0;
        end else begin
          w_cnt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_phase = IDLE;
        w_cnt   = 3'd0;
      end
    endcase

    if (w_start_pkt) begin
      w_phase   = PACKET;
      w_cnt     = 3'd0;
      w_pkt_idx = 5'd0;
      w_pkt_sel = w_sel_idx;
      w_grant   = w_sel_onehot;
      w_pkt_cnt = r_pkt_cnt + 2'd1;
    end

    if (r_phase != IDLE && de) begin
      w_phase   = IDLE;
      w_cnt     = 3'd0;
      w_pkt_cnt = 2'd0;
      w_pkt_idx = 5'd0;
      w_pkt_sel = 2'd0;
      w_grant   = 4'd0;
      w_abort   = 1'b1;
    end
  end

  assign phase   = r_phase;
  assign grant   = r_grant;
  assign pkt_sel = r_pkt_sel;
  assign pkt_idx = r_pkt_idx;
  assign abort   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_island_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_island_scheduler
// Description : Self-checking bench for island_scheduler. A pixel counter
//               drives sx/de; expected grants are queued when requests are
//               issued and matched when the DUT grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_island_scheduler;
  import hdmi_pkg::*;

  logic       clk_pix = 1'b0;
  logic       rst_in;
  logic [9:0] sx;
  logic       de;
  logic [3:0] req;
  logic [3:0] grant;
  logic [2:0] phase;
  logic [1:0] pkt_sel;
  logic [4:0] pkt_idx;
  logic [3:0] pending;
  logic       abort;

  typedef struct {
    logic [3:0] g;
    int         s;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  island_scheduler #(.ISLAND_START(650), .MAX_PKTS(2), .H_TOTAL(800)) dut (
    .clk_pix (clk_pix),
    .rst_in  (rst_in),
    .sx      (sx),
    .de      (de),
    .req     (req),
    .grant   (grant),
    .phase   (phase),
    .pkt_sel (pkt_sel),
    .pkt_idx (pkt_idx),
    .pending (pending),
    .abort   (abort)
  );

  always #5 clk_pix = ~clk_pix;

  // Expected phase at an observed sx for an island carrying n packets
  function automatic logic [2:0] exp_phase(input int s, input int n);
    if (n == 0) return IDLE;
    if (s >= 651 && s <= 658) return PREAMBLE;
    if (s >= 659 && s <= 660) return LEAD_GUARD;
    if (s >= 661 && s < 661 + 32 * n) return PACKET;
    if (s >= 661 + 32 * n && s < 663 + 32 * n) return TRAIL_GUARD;
    return IDLE;
  endfunction

  function automatic logic [4:0] exp_idx(input int s, input int n);
    if (exp_phase(s, n) == PACKET) return 5'((s - 661) % 32);
    return 5'd0;
  endfunction

  // Advance one pixel; inputs settle 1 time unit after the edge
  task automatic step();
    @(posedge clk_pix);
    #1;
    sx  = (sx == 10'd799) ? 10'd0 : sx + 10'd1;
    de  = (sx < 10'd640);
    req = 4'd0;
  endtask

  task automatic goto_sx(input int target);
    for (int k = 0; k < 2000; k++) begin
      step();
      if (int'(sx) == target) return;
    end
    n_vec++; n_err++;
    $display("FAIL goto_timeout got sx=%0d want sx=%0d", sx, target);
  endtask

  task automatic test_reset();
    n_vec++;
    if ({phase, grant, pkt_sel, pkt_idx, pending, abort} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs got phase=%0d grant=%b sel=%0d idx=%0d pend=%b abort=%b want all 0",
               phase, grant, pkt_sel, pkt_idx, pending, abort);
    end
  endtask

  // One request early in the line: one full island, one packet
  task automatic test_single();
    goto_sx(100);
    req = 4'b0001;
    q.push_back('{4'b0001, 661});
    step();
    n_vec++;
    if (pending !== 4'b0001) begin
      n_err++; $display("FAIL single_latch got pend=%b want 0001", pending);
    end
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (phase !== exp_phase(int'(sx), 1) || pkt_idx !== exp_idx(int'(sx), 1)) begin
        n_err++;
        $display("FAIL single_seq sx=%0d got phase=%0d idx=%0d want phase=%0d idx=%0d",
                 sx, phase, pkt_idx, exp_phase(int'(sx), 1), exp_idx(int'(sx), 1));
      end
      if (grant !== 4'd0) begin
        n_vec++;
        if (q.size() == 0 || phase !== PACKET) begin
          n_err++; $display("FAIL single_grant sx=%0d got %b want none", sx, grant);
        end else begin
          e = q.pop_front();
          if (grant !== e.g || int'(sx) != e.s) begin
            n_err++; $display("FAIL single_grant got %b@%0d want %b@%0d", grant, sx, e.g, e.s);
          end
        end
      end
      if (sx == 10'd700) break;
    end
    n_vec++;
    if (pending !== 4'd0 || q.size() != 0) begin
      n_err++; $display("FAIL single_end got pend=%b left=%0d want 0000 left=0", pending, q.size());
    end
  endtask

  // All four sources: two per island, remaining two on the next line
  task automatic test_two_lines();
    goto_sx(200);
    req = 4'b1111;
    q.push_back('{4'b0001, 661});
    q.push_back('{4'b0010, 693});
    for (int line = 0; line < 2; line++) begin
      for (int k = 0; k < 800; k++) begin
        step();
        n_vec++;
        if (phase !== exp_phase(int'(sx), 2) || pkt_idx !== exp_idx(int'(sx), 2)) begin
          n_err++;
          $display("FAIL two_seq line=%0d sx=%0d got phase=%0d idx=%0d want phase=%0d idx=%0d",
                   line, sx, phase, pkt_idx, exp_phase(int'(sx), 2), exp_idx(int'(sx), 2));
        end
        if (grant !== 4'd0) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++; $display("FAIL two_grant sx=%0d got %b want none", sx, grant);
          end else begin
            e = q.pop_front();
            if (grant !== e.g || int'(sx) != e.s) begin
              n_err++; $display("FAIL two_grant got %b@%0d want %b@%0d", grant, sx, e.g, e.s);
            end
          end
        end
        if (sx == 10'd740) break;
      end
      n_vec++;
      if (pending !== ((line == 0) ? 4'b1100 : 4'b0000) || q.size() != 0) begin
        n_err++;
        $display("FAIL two_pending line=%0d got pend=%b left=%0d want %b left=0",
                 line, pending, q.size(), (line == 0) ? 4'b1100 : 4'b0000);
      end
      q.push_back('{4'b0100, 661});
      q.push_back('{4'b1000, 693});
    end
    q.delete();
  endtask

  // Re-request of source 0 on its own grant cycle must survive the clear
  task automatic test_req_on_grant();
    goto_sx(300);
    req = 4'b0001;
    q.push_back('{4'b0001, 661});
    q.push_back('{4'b0001, 693});
    for (int k = 0; k < 800; k++) begin
      step();
      if (grant !== 4'd0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rog_grant sx=%0d got %b want none", sx, grant);
        end else begin
          e = q.pop_front();
          if (grant !== e.g || int'(sx) != e.s) begin
            n_err++; $display("FAIL rog_grant got %b@%0d want %b@%0d", grant, sx, e.g, e.s);
          end
        end
      end
      if (sx == 10'd661) req = 4'b0001;
      if (sx == 10'd662) begin
        n_vec++;
        if (pending[0] !== 1'b1) begin
          n_err++; $display("FAIL rog_keep got pend=%b want bit0=1", pending);
        end
      end
      if (sx == 10'd740) break;
    end
    n_vec++;
    if (pending !== 4'd0 || q.size() != 0) begin
      n_err++; $display("FAIL rog_end got pend=%b left=%0d want 0000 left=0", pending, q.size());
    end
  endtask

  // Nothing pending at the start point: idle line; late request waits a line
  task automatic test_idle_line();
    goto_sx(640);
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (phase !== IDLE || grant !== 4'd0) begin
        n_err++; $display("FAIL idle_line sx=%0d got phase=%0d grant=%b want 0/0000", sx, phase, grant);
      end
      if (sx == 10'd651) req = 4'b0100;
      if (sx == 10'd799) break;
    end
    q.push_back('{4'b0100, 661});
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (phase !== exp_phase(int'(sx), 1)) begin
        n_err++; $display("FAIL idle_next sx=%0d got phase=%0d want %0d", sx, phase, exp_phase(int'(sx), 1));
      end
      if (grant !== 4'd0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL idle_grant sx=%0d got %b want none", sx, grant);
        end else begin
          e = q.pop_front();
          if (grant !== e.g || int'(sx) != e.s) begin
            n_err++; $display("FAIL idle_grant got %b@%0d want %b@%0d", grant, sx, e.g, e.s);
          end
        end
      end
      if (sx == 10'd700) break;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL idle_left got %0d want 0", q.size());
    end
    q.delete();
  endtask

  // de asserted at pkt_idx 10: abort pulse, back to IDLE, grant stays consumed
  task automatic test_abort();
    goto_sx(400);
    req = 4'b0010;
    for (int k = 0; k < 800; k++) begin
      step();
      if (phase === PACKET && pkt_idx === 5'd10) break;
    end
    n_vec++;
    if (sx !== 10'd671) begin
      n_err++; $display("FAIL abort_reach got sx=%0d want 671", sx);
    end
    de = 1'b1;
    step();
    n_vec++;
    if (phase !== IDLE || abort !== 1'b1 || pending[1] !== 1'b0 || pkt_idx !== 5'd0) begin
      n_err++;
      $display("FAIL abort_pulse got phase=%0d abort=%b pend=%b idx=%0d want 0/1/bit1=0/0",
               phase, abort, pending, pkt_idx);
    end
    step();
    n_vec++;
    if (abort !== 1'b0 || phase !== IDLE) begin
      n_err++; $display("FAIL abort_single got abort=%b phase=%0d want 0/0", abort, phase);
    end
    for (int k = 0; k < 100; k++) begin
      step();
      n_vec++;
      if (grant !== 4'd0 || phase !== IDLE) begin
        n_err++; $display("FAIL abort_after sx=%0d got grant=%b phase=%0d want 0000/0", sx, grant, phase);
      end
    end
  endtask

  // Reset in the middle of the second packet clears everything at once
  task automatic test_reset_mid();
    goto_sx(500);
    req = 4'b0111;
    for (int k = 0; k < 800; k++) begin
      step();
      if (phase === PACKET && pkt_sel === 2'd1 && pkt_idx === 5'd5) break;
    end
    n_vec++;
    if (pending !== 4'b0100) begin
      n_err++; $display("FAIL rmid_pre got pend=%b want 0100", pending);
    end
    #2;
    rst_in = 1'b1;
    #1;
    n_vec++;
    if ({phase, grant, pkt_sel, pkt_idx, pending, abort} !== 19'd0) begin
      n_err++;
      $display("FAIL rmid_async got phase=%0d grant=%b sel=%0d idx=%0d pend=%b abort=%b want all 0",
               phase, grant, pkt_sel, pkt_idx, pending, abort);
    end
    goto_sx(720);
    rst_in = 1'b0;
    req = 4'b1000;
    q.delete();
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (phase !== IDLE) begin
        n_err++; $display("FAIL rmid_early sx=%0d got phase=%0d want 0", sx, phase);
      end
      if (sx == 10'd650) break;
    end
    q.push_back('{4'b1000, 661});
    for (int k = 0; k < 800; k++) begin
      step();
      n_vec++;
      if (phase !== exp_phase(int'(sx), 1)) begin
        n_err++; $display("FAIL rmid_next sx=%0d got phase=%0d want %0d", sx, phase, exp_phase(int'(sx), 1));
      end
      if (grant !== 4'd0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rmid_grant sx=%0d got %b want none", sx, grant);
        end else begin
          e = q.pop_front();
          if (grant !== e.g || int'(sx) != e.s || pkt_sel !== 2'd3) begin
            n_err++; $display("FAIL rmid_grant got %b@%0d sel=%0d want %b@%0d sel=3",
                              grant, sx, pkt_sel, e.g, e.s);
          end
        end
      end
      if (sx == 10'd700) break;
    end
    n_vec++;
    if (q.size() != 0 || pending !== 4'd0) begin
      n_err++; $display("FAIL rmid_end got left=%0d pend=%b want 0/0000", q.size(), pending);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    sx     = 10'd0;
    de     = 1'b1;
    req    = 4'd0;
    repeat (3) @(posedge clk_pix);
    #1;
    test_reset();
    rst_in = 1'b0;
    test_single();
    test_two_lines();
    test_req_on_grant();
    test_idle_line();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/island_scheduler.md
ISLAND_SCHEDULER -- requirements
Module: island_scheduler

Interface
REQ-001 Parameters SHALL be: ISLAND_START, 650, sx value whose following cycle begins the island preamble; MAX_PKTS, 2, packets per island (1..3); H_TOTAL, 800, line length in pixel clocks.
REQ-002 clk_pix  in  1  pixel clock; the only clock.
REQ-003 rst_in  in  1  reset, asynchronous, active-high.
REQ-004 sx  in  10  X position in the full frame, from display_timings.
REQ-005 de  in  1  visible-area flag, from display_timings.
REQ-006 req  in  4  single-cycle request pulses: [0] audio sample, [1] ACR, [2] AVI infoframe, [3] audio infoframe.
REQ-007 grant  out  4  one-hot pulse on the first clock of each granted packet.
REQ-008 phase  out  3  hdmi_pkg island phase: IDLE, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD.
REQ-009 pkt_sel  out  2  index of the source whose packet is being sent; valid while phase==PACKET.
REQ-010 pkt_idx  out  5  clock index inside the packet, 0..31.
REQ-011 pending  out  4  latched, not-yet-served requests.
REQ-012 abort  out  1  single-cycle pulse when an island is cut short by de.

Function
REQ-013 pending_next SHALL be (pending & ~grant) | req; a req coinciding with a grant of the same source SHALL leave its bit set.
REQ-014 In IDLE, when sx==ISLAND_START and pending!=0 (pending value in the same cycle), the FSM SHALL enter PREAMBLE on the next clock; otherwise it SHALL stay IDLE.
REQ-015 PREAMBLE SHALL last exactly 8 clocks, then LEAD_GUARD exactly 2 clocks, then PACKET.
REQ-016 On entry to each PACKET, the FSM SHALL select the highest-priority pending bit (bit 0 highest), drive pkt_sel, and pulse grant for that bit for one clock.
REQ-017 pkt_idx SHALL count 0..31 in PACKET and SHALL hold 0 in every other phase.
REQ-018 At pkt_idx==31, the FSM SHALL start another PACKET if pending (after clearing the current grant) !=0 and fewer than MAX_PKTS packets have been sent in this island; otherwise it SHALL enter TRAIL_GUARD.
REQ-019 Requests arriving during an island SHALL be eligible for that island's next packet.
REQ-020 TRAIL_GUARD SHALL last exactly 2 clocks, then IDLE; at most one island per line.
REQ-021 If de==1 in any non-IDLE phase, the FSM SHALL go to IDLE on the next clock and pulse abort; pending bits already granted SHALL stay cleared.
REQ-022 All outputs SHALL be registered; grant SHALL never be asserted outside phase==PACKET.
REQ-023 An elaboration check SHALL fail if ISLAND_START+12+32*MAX_PKTS > H_TOTAL-12.

Reset
REQ-024 On rst_in, regardless of phase, phase=IDLE, grant=0, pkt_sel=0, pkt_idx=0, pending=0, abort=0 and the packet counter=0, asynchronously.
REQ-025 After rst_in deasserts, the first island SHALL start no earlier than the next sx==ISLAND_START.

Structure
REQ-026 hdmi_pkg SHALL hold the phase enum, source index constants (SRC_AUD, SRC_ACR, SRC_AVI, SRC_AIF), PREAMBLE_LEN=8, GUARD_LEN=2 and PKT_LEN=32.
REQ-027 One sub-module, island_arbiter, SHALL contain the pending register and the fixed-priority one-hot select; the FSM and counters SHALL stay in island_scheduler.

Verification
REQ-028 req=4'b0001 at sx=100; line runs -> PREAMBLE at cycles after sx=650 for 8 clocks, guard 2, grant=0001 once, TRAIL_GUARD, IDLE at sx=695; pending=0.
REQ-029 req=4'b1111 before sx=650 -> two packets, grants 0001 then 0010, 32 clocks apart; pending=1100 afterward; the next line serves 0100 and 1000.
REQ-030 req[0] pulsed on the grant cycle of source 0 -> pending[0] still 1 after the grant; the next packet or island grants 0001 again.
REQ-031 pending=0 at sx=650 -> phase stays IDLE for the whole line; req[2] at sx=651 -> served on the next line.
REQ-032 de forced to 1 during PACKET at pkt_idx=10 -> abort pulse, phase=IDLE on the next clock, granted bit stays cleared.
REQ-033 rst_in asserted mid-PACKET -> all outputs zero immediately, without waiting for a clock edge; after release, no island starts before the next sx==650.
